// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - combinational single-bit full-adder cell
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, start/busy/done handshake
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only the upper WIDTH-1 sum bits need storing; the last bit comes straight from the cell.
    logic [WIDTH-2:0] s_sh;
    logic [WIDTH-1:0] s_full;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    serial_adder_fa u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign s_full = {fa_sum, s_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_full[WIDTH-1:1];
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        sum   <= s_full;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8 and 4
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    typedef struct {
        logic [8:0] res;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   chk_cnt = 0;
    logic prev_done4 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && done8) begin
            check("done8_busy_low", {31'd0, busy8}, 32'd0);
            if (q8.size() == 0) begin
                check("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("sum8", {23'd0, cout8, sum8}, {23'd0, e8.res});
                check("latency8", cyc, e8.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done4) begin
            check("done4_width", {31'd0, prev_done4}, 32'd0);
            if (q4.size() == 0) begin
                check("done4_unexpected", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                check("sum4", {27'd0, cout4, sum4}, {23'd0, e4.res});
                check("latency4", cyc, e4.cyc);
            end
        end
        prev_done4 = done4;
    end

    task automatic wait_done8(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done4(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done4) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // One accepted addition; optionally pulses start with other operands on RUN cycle 'glitch'.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int glitch, input logic [8:0] expres);
        int nbusy;
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back('{expres, cyc + 9});
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == glitch) begin
                start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                seen = 1'b1;
                break;
            end
            if (busy8) nbusy++;
        end
        check("done8_seen", {31'd0, seen}, 32'd1);
        check("busy8_cycles", nbusy, 32'd8);
    endtask

    initial begin
        bit seen;
        int ndone;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_sum8", {23'd0, cout8, sum8}, 32'd0);
        check("rst_sum4", {26'd0, busy4, cout4, sum4}, 32'd0);

        op8(8'd3, 8'd5, 1'b0, 0, 9'h008);
        op8(8'hFF, 8'h01, 1'b0, 0, 9'h100);
        op8(8'h00, 8'h00, 1'b1, 0, 9'h001);
        op8(8'd10, 8'd20, 1'b0, 3, 9'd30);

        // Abort mid-run: reset must clear the result and suppress done.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        check("abort_busy_before", {31'd0, busy8}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_sum", {23'd0, cout8, sum8}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        check("abort_no_done", ndone, 32'd0);

        // Back-to-back with start held high.
        a8 = 8'd100; b8 = 8'd27; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{9'd127, cyc + 9});
        wait_done8(seen);
        check("b2b_first_done", {31'd0, seen}, 32'd1);
        a8 = 8'd200; b8 = 8'd100;
        q8.push_back('{9'h12C, cyc + 9});
        wait_done8(seen);
        check("b2b_second_done", {31'd0, seen}, 32'd1);
        start8 = 1'b0;

        // Exhaustive WIDTH=4 sweep, back-to-back.
        @(negedge clk);
        for (int v = 0; v < 512; v++) begin
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
            q4.push_back('{9'(v[3:0]) + 9'(v[7:4]) + 9'(v[8]), cyc + 5});
            wait_done4(seen);
            if (!seen) begin
                check("sweep4_done", 32'd0, 32'd1);
                break;
            end
        end
        start4 = 1'b0;

        repeat (3) @(negedge clk);
        check("q8_drained", q8.size(), 32'd0);
        check("q4_drained", q4.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial multi-bit adder built around the team's single-bit full-adder cell (FA).
- Feeds the cell one operand bit pair per clock, LSB first, and carries cout back into cin through a flip-flop.
- Collects the sum bits in a shift register and presents a parallel WIDTH-bit result with a start/busy/done handshake.
- Sits between a parallel operand source and any consumer of a registered sum; trades latency for area versus a ripple array.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle onward.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered final carry; holds until the next completion.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers=0, carry FF=0, bit counter=0.
- States:
  - IDLE: start=1 → load A_sh<=a, B_sh<=b, carry<=cin, cnt<=0, go to RUN. Otherwise stay.
  - RUN: busy=1. Each edge: the FA cell evaluates (A_sh[0], B_sh[0], carry); its sum bit shifts into the MSB of S_sh (S_sh shifts right); carry<=FA cout; A_sh and B_sh shift right; cnt<=cnt+1. On the edge where cnt==WIDTH-1: sum<={fa_sum, S_sh[WIDTH-1:1]}, cout<=fa_cout, go to DONE.
  - DONE: done=1 and busy=0 for exactly this one cycle. start=1 → accept as in IDLE and go to RUN (back-to-back, no idle bubble). Otherwise go to IDLE.
- Latency: start is sampled at edge k; done is high in the cycle after edge k+WIDTH. Throughput is one addition per WIDTH+1 cycles when start is held high.
- start during RUN is ignored and not queued; a, b and cin may change freely after acceptance.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH). No overflow is possible because the counter is cleared on every accept.
- rst during RUN aborts the operation immediately. sum and cout clear to 0 and no done is produced. rst has priority over start in the same cycle.
- sum and cout never change except on a completion edge or on reset.

Decomposition:
- serial_adder_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - default-width constant SA_WIDTH_DEF=8.
- One sub-module: the existing combinational FA cell (ports a, b, cin, sum, cout), instantiated once. All sequential logic stays in serial_adder.

Test Plan:
1. WIDTH=8; reset, then start with a=3, b=5, cin=0 → busy for 8 cycles; done pulse in cycle 9 after the accept edge; sum=8'h08, cout=0.
2. a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Also a=0, b=0, cin=1 → sum=8'h01, cout=0.
3. Accept a=10, b=20; pulse start with a=1, b=1 at the 3rd RUN cycle → that start is ignored; result is sum=30; busy stays high exactly 8 cycles.
4. Accept a=8'hAA, b=8'h55, cin=1; assert rst at the 4th RUN cycle → next cycle IDLE, busy=0, sum=0, cout=0; no done within 20 cycles.
5. start held high with a new operand pair each DONE cycle → every result appears 9 cycles apart with no gap. Check back-to-back sums 100+27=127 and 200+100 → sum=44, cout=1.
6. WIDTH=4; all 512 combinations of a, b, cin → {cout,sum} matches a+b+cin every time; done is exactly one cycle wide.
